// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (16x oversampled, majority-voted bits) feeding a
// small synchronous receive FIFO.
//
// Ports:
//   clk            - single clock, rising edge
//   reset          - synchronous, active-low reset
//   serial         - asynchronous serial line, idle high
//   data           - byte at FIFO head
//   valid          - FIFO non-empty
//   ready          - consumer pop strobe (pop when valid && ready)
//   level          - FIFO occupancy, 0..FIFO_DEPTH
//   overflow       - sticky, a received byte was dropped on a full FIFO
//   overflow_clear - clears overflow
//   frame_error    - one-cycle pulse on a bad stop bit
//   parity_error   - one-cycle pulse on bad even parity (UART_RX_PARITY_EN only)
//
// Build option: define UART_RX_PARITY_EN for 8E1 framing; default is 8N1.
module uart_rx_fifo #(
    parameter int DIVISOR    = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          serial,
    output logic [7:0]                    data,
    output logic                          valid,
    input  logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    input  logic                          overflow_clear,
`ifdef UART_RX_PARITY_EN
    output logic                          parity_error,
`endif
    output logic                          frame_error
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int DIV16 = DIVISOR / 16;
    localparam int DCW   = (DIV16 > 1) ? $clog2(DIV16) : 1;
    localparam logic [AW:0]    DEPTH_L = FIFO_DEPTH[AW:0];
    localparam logic [DCW-1:0] DIV_MAX = DCW'(DIV16 - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_BRK    = 3'd5
    } state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

`ifdef UART_RX_PARITY_EN
    // Even parity: total count of ones over data and parity bit must be even.
    function automatic logic even_parity_bad(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction
`endif

    logic           sync1_r, sync2_r, prev_r;
    logic [DCW-1:0] div_cnt_r;
    state_t         state_r;
    logic [3:0]     os_cnt_r;
    logic [2:0]     bit_cnt_r;
    logic [1:0]     vote_r;
    logic [7:0]     shift_r;
    logic           push_r;
    logic [7:0]     push_data_r;
    logic           frame_error_r;
`ifdef UART_RX_PARITY_EN
    logic           par_bad_r;
    logic           parity_error_r;
`endif

    logic [7:0]     mem_r [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_r, rd_ptr_r;
    logic [AW:0]    count_r, count_nxt_s;
    logic           valid_r, overflow_r;

    logic start_det_s, tick_s, vote_s, mid_s, end_s;
    logic pop_s, full_s, accept_s, drop_s;

    // Sampling points: a bit is judged at oversample tick 9 using ticks 7, 8, 9.
    always_comb begin
        start_det_s = (state_r == ST_IDLE) && prev_r && !sync2_r;
        tick_s      = (div_cnt_r == DIV_MAX);
        vote_s      = majority3(vote_r[0], vote_r[1], sync2_r);
        mid_s       = tick_s && (os_cnt_r == 4'd9);
        end_s       = tick_s && (os_cnt_r == 4'd15);
    end

    // Two-flop synchronizer plus a history flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= serial;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Free-running oversample divider, realigned on every start-bit edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt_r <= '0;
        end else if (start_det_s || tick_s) begin
            div_cnt_r <= '0;
        end else begin
            div_cnt_r <= div_cnt_r + {{(DCW-1){1'b0}}, 1'b1};
        end
    end

    // Receive FSM: bit timing, majority voting, byte assembly and error pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            os_cnt_r      <= 4'd0;
            bit_cnt_r     <= 3'd0;
            vote_r        <= 2'b00;
            shift_r       <= 8'd0;
            push_r        <= 1'b0;
            push_data_r   <= 8'd0;
            frame_error_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_r      <= 1'b0;
            parity_error_r <= 1'b0;
`endif
        end else begin
            push_r        <= 1'b0;
            frame_error_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error_r <= 1'b0;
`endif
            if (tick_s && (state_r != ST_IDLE)) begin
                os_cnt_r <= os_cnt_r + 4'd1;
            end
            if (tick_s && (os_cnt_r == 4'd7)) begin
                vote_r[0] <= sync2_r;
            end
            if (tick_s && (os_cnt_r == 4'd8)) begin
                vote_r[1] <= sync2_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start_det_s) begin
                        state_r   <= ST_START;
                        os_cnt_r  <= 4'd0;
                        bit_cnt_r <= 3'd0;
`ifdef UART_RX_PARITY_EN
                        par_bad_r <= 1'b0;
`endif
                    end
                end
                ST_START: begin
                    // A start bit that reads high at mid-bit was a glitch.
                    if (mid_s && vote_s) begin
                        state_r <= ST_IDLE;
                    end else if (end_s) begin
                        state_r <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (mid_s) begin
                        shift_r <= {vote_s, shift_r[7:1]};
                    end
                    if (end_s) begin
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_r <= ST_PARITY;
`else
                            state_r <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (mid_s) begin
                        par_bad_r      <= even_parity_bad(shift_r, vote_s);
                        parity_error_r <= even_parity_bad(shift_r, vote_s);
                    end
                    if (end_s) begin
                        state_r <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    // Leave at mid stop bit so a following start edge is not missed.
                    if (mid_s) begin
                        if (vote_s) begin
`ifdef UART_RX_PARITY_EN
                            push_r <= !par_bad_r;
`else
                            push_r <= 1'b1;
`endif
                            push_data_r <= shift_r;
                            state_r     <= ST_IDLE;
                        end else begin
                            frame_error_r <= 1'b1;
                            state_r       <= ST_BRK;
                        end
                    end
                end
                ST_BRK: begin
                    if (sync2_r) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // FIFO control: a pop frees a slot in the same cycle, so full+pop accepts.
    always_comb begin
        pop_s       = valid_r && ready;
        full_s      = (count_r == DEPTH_L);
        accept_s    = push_r && (!full_s || pop_s);
        drop_s      = push_r && full_s && !pop_s;
        count_nxt_s = count_r;
        case ({accept_s, pop_s})
            2'b10:   count_nxt_s = count_r + {{AW{1'b0}}, 1'b1};
            2'b01:   count_nxt_s = count_r - {{AW{1'b0}}, 1'b1};
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO pointers, occupancy, valid flag and sticky overflow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != '0);
            // A drop in the same cycle as a clear wins.
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (overflow_clear) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= push_data_r;
        end
    end

    assign data        = mem_r[rd_ptr_r];
    assign valid       = valid_r;
    assign level       = count_r;
    assign overflow    = overflow_r;
    assign frame_error = frame_error_r;
`ifdef UART_RX_PARITY_EN
    assign parity_error = parity_error_r;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo (DIVISOR=32, FIFO_DEPTH=4). Drives serial frames
// bit by bit and compares received bytes, levels and flags against a queue
// model of what a correct receiver plus FIFO should deliver.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       serial = 1'b1;
    logic       ready = 1'b0;
    logic       overflow_clear = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic [2:0] level;
    logic       overflow;
    logic       frame_error;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
    int         pe_cnt = 0;
`endif

    int checks = 0;
    int errors = 0;
    byte unsigned exp_q[$];
    byte unsigned got_q[$];
    int  fe_cnt = 0;
    int  vcyc = 0;
    bit  rand_rdy = 1'b0;
    bit  model_ovf = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DIVISOR(32), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .serial         (serial),
        .data           (data),
        .valid          (valid),
        .ready          (ready),
        .level          (level),
        .overflow       (overflow),
        .overflow_clear (overflow_clear),
`ifdef UART_RX_PARITY_EN
        .parity_error   (parity_error),
`endif
        .frame_error    (frame_error)
    );

    // Observe pops and pulses away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            if (valid && ready) got_q.push_back(data);
            if (frame_error) fe_cnt++;
            if (valid) vcyc++;
`ifdef UART_RX_PARITY_EN
            if (parity_error) pe_cnt++;
`endif
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_rdy) ready = 1'($urandom_range(0, 1));
        end
    endtask

    // Compare every delivered byte with the model's expected stream.
    task automatic check_stream(input string tag);
        check_val({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check_val($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    // One frame: start, 8 data bits LSB first, [even parity], stop, idle gap.
    task automatic send_frame(input logic [7:0] b, input bit stop_b, input bit par_ok);
        serial = 1'b0;
        step(32);
        for (int i = 0; i < 8; i++) begin
            serial = b[i];
            step(32);
        end
`ifdef UART_RX_PARITY_EN
        serial = (^b) ^ !par_ok;
        step(32);
`endif
        serial = stop_b;
        step(32);
        serial = 1'b1;
        step(16);
        // Model: a good frame enters the FIFO unless it already holds 4 bytes.
        if (stop_b && par_ok) begin
            if (exp_q.size() - got_q.size() >= 4) model_ovf = 1'b1;
            else exp_q.push_back(b);
        end
    endtask

    initial begin
        // Reset state
        reset = 1'b0;
        step(5);
        check_val("rst_valid", valid, 0);
        check_val("rst_level", level, 0);
        check_val("rst_overflow", overflow, 0);
        check_val("rst_frame_error", frame_error, 0);
        reset = 1'b1;
        step(5);

        // Single byte with ready high
        ready = 1'b1;
        vcyc = 0;
        fe_cnt = 0;
        send_frame(8'hA5, 1'b1, 1'b1);
        step(10);
        check_stream("a5");
        check_val("a5_valid_cycles", vcyc, 1);
        check_val("a5_frame_error", fe_cnt, 0);
        check_val("a5_level", level, 0);

        // Short low glitch must not start a frame
        serial = 1'b0;
        step(2);
        serial = 1'b1;
        step(64);
        check_stream("glitch");
        check_val("glitch_valid_cycles", vcyc, 1);
        check_val("glitch_frame_error", fe_cnt, 0);

        // Random bytes with random consumer back-pressure
        rand_rdy = 1'b1;
        for (int k = 0; k < 6; k++) send_frame(8'($urandom), 1'b1, 1'b1);
        rand_rdy = 1'b0;
        ready = 1'b1;
        step(20);
        check_stream("rand");
        check_val("rand_level", level, 0);

        // Overflow: five bytes into a four-entry FIFO with no consumer
        ready = 1'b0;
        for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, 1'b1);
        check_val("ovf_level", level, 4);
        check_val("ovf_flag", overflow, int'(model_ovf));
        check_val("ovf_head", data, 8'h01);
        step(10);
        check_val("ovf_head_stable", data, 8'h01);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("pop%0d_data", i), data, i + 1);
            check_val($sformatf("pop%0d_level", i), level, 4 - i);
            ready = 1'b1;
            step(1);
            ready = 1'b0;
            step(1);
        end
        check_val("ovf_drained_valid", valid, 0);
        check_val("ovf_drained_level", level, 0);
        check_stream("ovf");
        check_val("ovf_sticky", overflow, 1);
        overflow_clear = 1'b1;
        step(1);
        overflow_clear = 1'b0;
        model_ovf = 1'b0;
        step(1);
        check_val("ovf_cleared", overflow, int'(model_ovf));

        // Framing error then a clean byte
        ready = 1'b1;
        fe_cnt = 0;
        send_frame(8'h3C, 1'b0, 1'b1);
        step(32);
        check_val("fe_pulse", fe_cnt, 1);
        check_stream("fe_nopush");
        send_frame(8'h7E, 1'b1, 1'b1);
        step(10);
        check_stream("fe_next");
        check_val("fe_no_extra", fe_cnt, 1);

        // Reset in the middle of a frame while the FIFO holds a byte
        ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b1);
        step(5);
        check_val("prerst_valid", valid, 1);
        check_val("prerst_level", level, 1);
        serial = 1'b0;
        step(32);
        serial = 1'b1;
        step(32);
        serial = 1'b0;
        step(40);
        reset = 1'b0;
        step(2);
        check_val("midrst_valid", valid, 0);
        check_val("midrst_level", level, 0);
        check_val("midrst_frame_error", frame_error, 0);
        check_val("midrst_overflow", overflow, 0);
        serial = 1'b1;
        step(60);
        check_val("midrst_valid_hold", valid, 0);
        reset = 1'b1;
        exp_q.delete();
        got_q.delete();
        step(10);
        ready = 1'b1;
        send_frame(8'h42, 1'b1, 1'b1);
        step(10);
        check_stream("postrst");

`ifdef UART_RX_PARITY_EN
        // Bad parity is reported and discarded, good parity is delivered
        pe_cnt = 0;
        send_frame(8'h03, 1'b1, 1'b0);
        step(10);
        check_val("par_bad_pulse", pe_cnt, 1);
        check_stream("par_bad");
        send_frame(8'h03, 1'b1, 1'b1);
        step(10);
        check_val("par_good_nopulse", pe_cnt, 1);
        check_stream("par_good");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DIVISOR, default 32, clocks per serial bit; must be a multiple of 16 and at least 16.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO entries; must be a power of two and at least 2.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-005 SHALL have port serial  input  1  asynchronous line, idle high, 8N1 (8E1 with parity).
REQ-006 SHALL have port data  output  8  byte at FIFO head.
REQ-007 SHALL have port valid  output  1  FIFO non-empty, data meaningful.
REQ-008 SHALL have port ready  input  1  consumer pop; pop occurs when valid && ready.
REQ-009 SHALL have port level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-010 SHALL have port overflow  output  1  sticky; a byte was dropped because the FIFO was full.
REQ-011 SHALL have port overflow_clear  input  1  clears overflow.
REQ-012 SHALL have port frame_error  output  1  one-cycle pulse on a bad stop bit.

Function
REQ-013 SHALL pass serial through a 2-flop synchronizer; all decoding SHALL use the synchronized value.
REQ-014 SHALL generate a 16x oversample tick every DIVISOR/16 clocks from a free-running counter that restarts on each start-bit detection.
REQ-015 SHALL implement states IDLE, START, DATA, STOP, BREAK (plus PARITY under REQ-030).
REQ-016 IDLE: on a synchronized 1->0 transition, go to START with the oversample count at 0.
REQ-017 START: at oversample ticks 7, 8 and 9, take the majority vote; majority 1 = glitch, return to IDLE with no output; majority 0 = go to DATA.
REQ-018 DATA: sample 8 bits LSB first, each as the majority of ticks 7/8/9 of its bit period.
REQ-019 STOP: majority 1 = push byte; majority 0 = pulse frame_error for 1 clk, discard byte, go to BREAK.
REQ-020 BREAK: stay until the synchronized line is 1, then go to IDLE.
REQ-021 After a valid stop sample, return to IDLE at stop tick 9; a falling edge after that point SHALL be accepted as a new start.
REQ-022 Push when FIFO full and no same-cycle pop: drop the byte, set overflow, leave FIFO contents unchanged.
REQ-023 Push when FIFO full with a same-cycle pop: accept the byte; level unchanged.
REQ-024 Push and pop on the same cycle when level=1: pop the old byte, push the new one; valid stays 1.
REQ-025 Pushed byte SHALL appear on data/valid the clock after the push when the FIFO was empty (latency 1).
REQ-026 data SHALL be stable while valid && !ready.
REQ-027 Read and write pointers SHALL wrap modulo FIFO_DEPTH; level SHALL range from 0 to FIFO_DEPTH inclusive.
REQ-028 overflow_clear SHALL clear overflow; if a drop happens the same cycle, overflow SHALL remain 1.

Reset
REQ-029 While reset=0 at a clk edge, the block SHALL set state=IDLE, FIFO empty (valid=0, level=0), overflow=0, frame_error=0, oversample counters=0 and synchronizer=11; a byte in flight SHALL be discarded.

Configuration
REQ-030 With UART_RX_PARITY_EN defined: frame is 8E1; a PARITY state between DATA and STOP samples the parity bit; an output port parity_error (1 bit, one-cycle pulse) SHALL be added; a byte with odd total parity SHALL pulse parity_error and be discarded, with STOP still checked.
REQ-031 Without UART_RX_PARITY_EN: frame is 8N1, and the parity_error port and PARITY state SHALL be absent.

Verification (DIVISOR=32, FIFO_DEPTH=4, no parity unless stated)
REQ-032 Send 0xA5 with ready=1 -> single valid cycle with data=0xA5; frame_error=0; level returns to 0.
REQ-033 Hold serial low for 2 clk in IDLE -> no valid, no frame_error, state returns to IDLE.
REQ-034 Send 5 bytes 0x01..0x05 with ready=0 -> level=4, overflow=1, pops yield 0x01..0x04; pulse overflow_clear -> overflow=0.
REQ-035 Send 0x3C with stop bit 0, then idle high -> frame_error pulse, no push; next byte 0x7E is received correctly.
REQ-036 Assert reset=0 mid-byte, release, send 0x42 -> only 0x42 is received; all outputs were at reset values during reset.
REQ-037 Parity build: send 0x03 with parity bit 1 -> parity_error pulse, no push; send 0x03 with parity bit 0 -> data=0x03.
